// File: rtl/ysyx_23060020_wbarb.sv
// Writeback arbiter: merges EXU and LSU writebacks onto one register-file write
// port and keeps the per-register busy scoreboard used for issue stalls.
module ysyx_23060020_wbarb (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_valid,
   input  logic [4:0]  exu_rd,
   input  logic [31:0] exu_data,
   output logic        exu_ready,
   input  logic        lsu_valid,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_data,
   output logic        lsu_ready,
   output logic        rfwen,
   output logic [4:0]  w1a,
   output logic [31:0] w1d,
   input  logic        alloc_valid,
   input  logic [4:0]  alloc_rd,
   output logic        alloc_ready,
   input  logic [4:0]  chk_r1a,
   input  logic [4:0]  chk_r2a,
   output logic        stall
);

   // Handshake: a transfer happens on a rising edge where valid && ready. Ready
   // is combinational from valid, so a lone requester is taken in its first
   // cycle; a requester must hold valid/rd/data stable until that edge.

   logic        prio_q, prio_d;
   logic [31:0] busy_q, busy_d;
   logic        rfwen_q, rfwen_d;
   logic [4:0]  w1a_q, w1a_d;
   logic [31:0] w1d_q, w1d_d;
   logic        exu_gnt, lsu_gnt;
   logic        alloc_ok;

   function automatic logic is_busy(input logic [31:0] b, input logic [4:0] a);
      return (a != 5'd0) && b[a];
   endfunction

   always_comb begin
      exu_gnt = exu_valid && (!lsu_valid || !prio_q);
      lsu_gnt = lsu_valid && (!exu_valid || prio_q);
   end

   // Outputs are forced low while reset is held, independent of the clock.
   assign exu_ready   = rst && exu_gnt;
   assign lsu_ready   = rst && lsu_gnt;
   assign alloc_ok    = (alloc_rd == 5'd0) || !busy_q[alloc_rd];
   assign alloc_ready = rst && alloc_ok;
   assign stall       = rst && (is_busy(busy_q, chk_r1a) || is_busy(busy_q, chk_r2a));

   assign rfwen = rfwen_q;
   assign w1a   = w1a_q;
   assign w1d   = w1d_q;

   always_comb begin
      prio_d  = prio_q;
      rfwen_d = 1'b0;
      w1a_d   = 5'd0;
      w1d_d   = 32'd0;
      if (exu_gnt) begin
         prio_d  = 1'b1;
         rfwen_d = (exu_rd != 5'd0);
         w1a_d   = exu_rd;
         w1d_d   = exu_data;
      end else if (lsu_gnt) begin
         prio_d  = 1'b0;
         rfwen_d = (lsu_rd != 5'd0);
         w1a_d   = lsu_rd;
         w1d_d   = lsu_data;
      end
   end

   // Clear on the commit edge so an issue in the next cycle reads the new value;
   // a same-edge allocation to a different register is applied alongside.
   always_comb begin
      busy_d = busy_q;
      if (rfwen_q) begin
         busy_d[w1a_q] = 1'b0;
      end
      if (alloc_valid && alloc_ok && (alloc_rd != 5'd0)) begin
         busy_d[alloc_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_q  <= 1'b0;
         busy_q  <= 32'd0;
         rfwen_q <= 1'b0;
         w1a_q   <= 5'd0;
         w1d_q   <= 32'd0;
      end else begin
         prio_q  <= prio_d;
         busy_q  <= busy_d;
         rfwen_q <= rfwen_d;
         w1a_q   <= w1a_d;
         w1d_q   <= w1d_d;
      end
   end

endmodule
